// File: rtl/i2s_pkg.sv
// Shared constants and sizing helpers for the I2S/TDM transmit engine.
package i2s_pkg;

  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_LJ  = 1'b1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] RESYNC = 2'd2;

  function automatic int frame_bits(input int num_channels, input int slot_width);
    return num_channels * slot_width;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// MCLK/BCLK dividers; bclk_fall marks the cycle in which BCLK drops.
module i2s_clock_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_run,
  input  logic [DIV_WIDTH-1:0] bclk_div,
  input  logic [DIV_WIDTH-1:0] mclk_div,
  output logic                 i2s_mclock,
  output logic                 i2s_clock,
  output logic                 bclk_fall
);

  logic [DIV_WIDTH-1:0] bcnt;
  logic [DIV_WIDTH-1:0] mcnt;
  logic                 btick;
  logic                 mtick;

  assign btick     = clk_run && (bcnt == bclk_div);
  assign mtick     = clk_run && (mcnt == mclk_div);
  assign bclk_fall = btick && i2s_clock;

  always_ff @(posedge clk) begin
    if (rst || !clk_run) begin
      bcnt       <= '0;
      mcnt       <= '0;
      i2s_clock  <= 1'b0;
      i2s_mclock <= 1'b0;
    end else begin
      bcnt <= btick ? '0 : bcnt + DIV_WIDTH'(1);
      mcnt <= mtick ? '0 : mcnt + DIV_WIDTH'(1);
      if (btick) i2s_clock  <= ~i2s_clock;
      if (mtick) i2s_mclock <= ~i2s_mclock;
    end
  end

endmodule

// File: rtl/i2s_tx_engine.sv
// I2S/TDM transmit engine: one-entry holding register, slot serialiser,
// underrun tracking and frame resynchronisation.
module i2s_tx_engine
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int NUM_CHANNELS = 2,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    mode_lj,
  input  logic [DIV_WIDTH-1:0]    bclk_div,
  input  logic [DIV_WIDTH-1:0]    mclk_div,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  input  logic                    underrun_clear,
  output logic                    underrun,
  output logic [15:0]             underrun_count,
  output logic                    i2s_mclock,
  output logic                    i2s_clock,
  output logic                    i2s_data,
  output logic                    i2s_lr
);

  localparam int FRAME_BITS = frame_bits(NUM_CHANNELS, SLOT_WIDTH);
  localparam int FI_W       = idx_width(FRAME_BITS);

  logic [1:0]              state, state_nxt;
  logic                    mode_q;
  logic [DIV_WIDTH-1:0]    bdiv_q, mdiv_q;
  logic                    clk_run, bclk_fall, started;
  logic [FI_W-1:0]         fi, fi_nxt, di;
  int                      bit_pos, slot_idx;
  logic [SAMPLE_WIDTH-1:0] hold, shift, shift_nxt;
  logic                    hold_valid, xfer, consume, urun_evt;
  logic                    data_nxt, lr_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign clk_run      = enable && (state != IDLE);
  assign sample_ready = enable && !hold_valid;
  assign xfer         = sample_valid && sample_ready;

  i2s_clock_gen #(.DIV_WIDTH(DIV_WIDTH)) u_clock_gen (
    .clk        (clk),
    .rst        (rst),
    .clk_run    (clk_run),
    .bclk_div   (bdiv_q),
    .mclk_div   (mdiv_q),
    .i2s_mclock (i2s_mclock),
    .i2s_clock  (i2s_clock),
    .bclk_fall  (bclk_fall)
  );

  // Next bit period: frame position, data position and slot-load decision
  always_comb begin
    fi_nxt = '0;
    if (started) fi_nxt = (fi == FI_W'(FRAME_BITS - 1)) ? '0 : fi + FI_W'(1);
    if (mode_q == MODE_LJ)  di = fi_nxt;
    else if (fi_nxt == '0)  di = FI_W'(FRAME_BITS - 1);
    else                    di = fi_nxt - FI_W'(1);
    bit_pos   = int'(di) % SLOT_WIDTH;
    slot_idx  = int'(di) / SLOT_WIDTH;
    state_nxt = state;
    consume   = 1'b0;
    urun_evt  = 1'b0;
    shift_nxt = shift << 1;
    if (bit_pos == 0) begin
      // In RESYNC a waiting sample is held back until channel 0 comes round
      if (hold_valid && (state == RUN || slot_idx == 0)) begin
        shift_nxt = hold;
        consume   = 1'b1;
        state_nxt = RUN;
      end else begin
        shift_nxt = '0;
        urun_evt  = !hold_valid;
        state_nxt = RESYNC;
      end
    end
    data_nxt = (bit_pos < SAMPLE_WIDTH) && shift_nxt[SAMPLE_WIDTH-1];
    if (!started && mode_q == MODE_I2S) data_nxt = 1'b0;
    lr_nxt = (int'(fi_nxt) >= FRAME_BITS / 2);
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state      <= IDLE;
      mode_q     <= MODE_I2S;
      bdiv_q     <= '0;
      mdiv_q     <= '0;
      started    <= 1'b0;
      fi         <= '0;
      shift      <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      i2s_data   <= 1'b0;
      i2s_lr     <= 1'b0;
    end else begin
      if (state == IDLE) begin
        state  <= RUN;
        mode_q <= mode_lj;
        bdiv_q <= bclk_div;
        mdiv_q <= mclk_div;
      end
      if (xfer) begin
        hold       <= sample_data;
        hold_valid <= 1'b1;
      end else if (bclk_fall && consume) begin
        hold_valid <= 1'b0;
      end
      if (bclk_fall) begin
        state    <= state_nxt;
        started  <= 1'b1;
        fi       <= fi_nxt;
        shift    <= shift_nxt;
        i2s_data <= data_nxt;
        i2s_lr   <= lr_nxt;
      end
    end
  end

  // Underrun flag and count survive enable going low
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun       <= 1'b0;
      underrun_count <= 16'd0;
    end else if (underrun_clear) begin
      underrun       <= bclk_fall && urun_evt;
      underrun_count <= (bclk_fall && urun_evt) ? 16'd1 : 16'd0;
    end else if (bclk_fall && urun_evt) begin
      underrun       <= 1'b1;
      underrun_count <= sat_inc(underrun_count);
    end
  end

endmodule

// File: tb/tb_i2s_tx_engine.sv
// Directed bench for i2s_tx_engine: default 2x32/24 instance and a 4x16/16 TDM instance.
module tb_i2s_tx_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, mode_lj, sample_valid, underrun_clear;
  logic [15:0] bclk_div, mclk_div;
  logic [23:0] sample_data;
  logic        sample_ready, underrun, i2s_mclock, i2s_clock, i2s_data, i2s_lr;
  logic [15:0] underrun_count;

  logic        enable_4, mode_lj_4, sample_valid_4, underrun_clear_4;
  logic [15:0] bclk_div_4, mclk_div_4;
  logic [15:0] sample_data_4;
  logic        sample_ready_4, underrun_4, i2s_mclock_4, i2s_clock_4, i2s_data_4, i2s_lr_4;
  logic [15:0] underrun_count_4;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] q[$];
  logic [15:0] q4[$];
  logic        fire  = 1'b0;
  logic        fire4 = 1'b0;

  always #5 clk = ~clk;

  i2s_tx_engine dut (
    .clk(clk), .rst(rst), .enable(enable), .mode_lj(mode_lj),
    .bclk_div(bclk_div), .mclk_div(mclk_div),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
    .underrun_clear(underrun_clear), .underrun(underrun), .underrun_count(underrun_count),
    .i2s_mclock(i2s_mclock), .i2s_clock(i2s_clock), .i2s_data(i2s_data), .i2s_lr(i2s_lr)
  );

  i2s_tx_engine #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .NUM_CHANNELS(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable_4), .mode_lj(mode_lj_4),
    .bclk_div(bclk_div_4), .mclk_div(mclk_div_4),
    .sample_valid(sample_valid_4), .sample_ready(sample_ready_4), .sample_data(sample_data_4),
    .underrun_clear(underrun_clear_4), .underrun(underrun_4), .underrun_count(underrun_count_4),
    .i2s_mclock(i2s_mclock_4), .i2s_clock(i2s_clock_4), .i2s_data(i2s_data_4), .i2s_lr(i2s_lr_4)
  );

  // Stream feeders: present queue head, pop after an accepted handshake
  initial begin
    sample_valid = 1'b0;
    sample_data  = '0;
    forever begin
      @(negedge clk); #1;
      if (fire && q.size() > 0) void'(q.pop_front());
      sample_valid = (q.size() > 0);
      sample_data  = (q.size() > 0) ? q[0] : 24'h0;
      #2;
      fire = sample_valid && sample_ready;
    end
  end

  initial begin
    sample_valid_4 = 1'b0;
    sample_data_4  = '0;
    forever begin
      @(negedge clk); #1;
      if (fire4 && q4.size() > 0) void'(q4.pop_front());
      sample_valid_4 = (q4.size() > 0);
      sample_data_4  = (q4.size() > 0) ? q4[0] : 16'h0;
      #2;
      fire4 = sample_valid_4 && sample_ready_4;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] exp_frame(input logic [23:0] a, input logic [23:0] b);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 24; i++) begin
      v[i]      = a[23-i];
      v[32 + i] = b[23-i];
    end
    return v;
  endfunction

  task automatic get_bit(output logic d, output logic lr, output int cyc);
    logic prev;
    bit   done;
    prev = i2s_clock; done = 0; cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk); cyc++;
      if (prev && !i2s_clock) done = 1;
      prev = i2s_clock;
    end
    d = i2s_data; lr = i2s_lr;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL bclk_timeout: no BCLK fall within %0d cycles", cyc);
    end
  endtask

  task automatic get_bit4(output logic d, output logic lr);
    logic prev;
    bit   done;
    int   cyc;
    prev = i2s_clock_4; done = 0; cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk); cyc++;
      if (prev && !i2s_clock_4) done = 1;
      prev = i2s_clock_4;
    end
    d = i2s_data_4; lr = i2s_lr_4;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL bclk4_timeout: no BCLK fall within %0d cycles", cyc);
    end
  endtask

  task automatic wait_mrise(output int cyc);
    logic prev;
    bit   done;
    prev = i2s_mclock; done = 0; cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk); cyc++;
      if (!prev && i2s_mclock) done = 1;
      prev = i2s_mclock;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL mclk_timeout: no MCLK rise within %0d cycles", cyc);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable = 0; mode_lj = 0; bclk_div = 0; mclk_div = 0; underrun_clear = 0;
    enable_4 = 0; mode_lj_4 = 0; bclk_div_4 = 0; mclk_div_4 = 0; underrun_clear_4 = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({i2s_mclock, i2s_clock, i2s_data, i2s_lr, sample_ready, underrun} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {i2s_mclock, i2s_clock, i2s_data, i2s_lr, sample_ready, underrun});
    end
    n_tests++;
    if (underrun_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_count: got %h expected 0000", underrun_count);
    end
    n_tests++;
    if ({i2s_mclock_4, i2s_clock_4, i2s_data_4, i2s_lr_4, sample_ready_4, underrun_4} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs4: got %b expected 000000",
               {i2s_mclock_4, i2s_clock_4, i2s_data_4, i2s_lr_4, sample_ready_4, underrun_4});
    end
    n_tests++;
    if (underrun_count_4 !== 16'd0) begin
      n_fail++; $display("FAIL reset_count4: got %h expected 0000", underrun_count_4);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lj;
    logic [63:0] dv, lv, ev;
    logic        d, l;
    int          c, c_bad;
    q.push_back(24'hABCDEF); q.push_back(24'h123456);
    mode_lj = 1; bclk_div = 1; mclk_div = 1; enable = 1;
    c_bad = 0;
    for (int k = 0; k < 64; k++) begin
      get_bit(d, l, c);
      dv[k] = d; lv[k] = l;
      if (k > 0 && c != 4) c_bad++;
    end
    ev = exp_frame(24'hABCDEF, 24'h123456);
    n_tests++;
    if (dv !== ev) begin n_fail++; $display("FAIL lj_data: got %h expected %h", dv, ev); end
    n_tests++;
    if (lv !== {32'hFFFF_FFFF, 32'h0}) begin
      n_fail++; $display("FAIL lj_lr: got %h expected ffffffff00000000", lv);
    end
    n_tests++;
    if (c_bad !== 0) begin n_fail++; $display("FAIL lj_bit_len: %0d bits not 4 clk long, expected 0", c_bad); end
    enable = 0;
    @(negedge clk);
  endtask

  task automatic test_i2s;
    logic [63:0] dv, lv, ev;
    logic        d, l;
    int          c;
    q.push_back(24'hABCDEF); q.push_back(24'h123456);
    mode_lj = 0; bclk_div = 1; mclk_div = 1; enable = 1;
    for (int k = 0; k < 64; k++) begin
      get_bit(d, l, c);
      dv[k] = d; lv[k] = l;
    end
    ev = exp_frame(24'hABCDEF, 24'h123456) << 1;
    n_tests++;
    if (dv !== ev) begin n_fail++; $display("FAIL i2s_data: got %h expected %h", dv, ev); end
    n_tests++;
    if (lv !== {32'hFFFF_FFFF, 32'h0}) begin
      n_fail++; $display("FAIL i2s_lr: got %h expected ffffffff00000000", lv);
    end
    n_tests++;
    if (dv[1:0] !== 2'b10) begin n_fail++; $display("FAIL i2s_msb_delay: got bits1..0=%b expected 10", dv[1:0]); end
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL i2s_no_underrun: got %b expected 0", underrun); end
    enable = 0;
    @(negedge clk);
  endtask

  task automatic test_clocks;
    logic d, l;
    int   c;
    mode_lj = 1; bclk_div = 0; mclk_div = 3; enable = 1;
    get_bit(d, l, c); get_bit(d, l, c);
    n_tests++;
    if (c !== 2) begin n_fail++; $display("FAIL bclk_period_div0: got %0d expected 2", c); end
    wait_mrise(c); wait_mrise(c);
    n_tests++;
    if (c !== 8) begin n_fail++; $display("FAIL mclk_period_div3: got %0d expected 8", c); end
    bclk_div = 3;
    get_bit(d, l, c); get_bit(d, l, c);
    n_tests++;
    if (c !== 2) begin n_fail++; $display("FAIL bclk_div_midrun: got %0d expected 2", c); end
    enable = 0;
    @(negedge clk);
    enable = 1;
    get_bit(d, l, c); get_bit(d, l, c);
    n_tests++;
    if (c !== 8) begin n_fail++; $display("FAIL bclk_div_relatch: got %0d expected 8", c); end
    enable = 0;
    @(negedge clk);
  endtask

  task automatic test_underrun;
    logic [23:0] f2l, f3;
    logic [31:0] r2;
    logic        d, l, f3lr, ready_mid, ur127;
    logic [15:0] cnt127;
    int          c;
    underrun_clear = 1;
    @(negedge clk);
    underrun_clear = 0;
    n_tests++;
    if ({underrun, underrun_count} !== 17'd0) begin
      n_fail++; $display("FAIL clear_idle: got flag=%b count=%h expected 0/0000", underrun, underrun_count);
    end
    q.push_back(24'h111111); q.push_back(24'h222222); q.push_back(24'h333333);
    mode_lj = 1; bclk_div = 0; mclk_div = 0; enable = 1;
    f3lr = 0; ready_mid = 1'bx; ur127 = 1'bx; cnt127 = 'x;
    for (int k = 0; k <= 168; k++) begin
      get_bit(d, l, c);
      if (k == 104) begin q.push_back(24'h444444); q.push_back(24'h555555); end
      if (k >= 64 && k < 88) f2l[23-(k-64)] = d;
      if (k >= 96 && k < 128) r2[k-96] = d;
      if (k >= 128 && k < 152) begin f3[23-(k-128)] = d; f3lr = f3lr | l; end
      if (k == 114) ready_mid = sample_ready;
      if (k == 127) begin ur127 = underrun; cnt127 = underrun_count; end
    end
    n_tests++;
    if (f2l !== 24'h333333) begin n_fail++; $display("FAIL ur_frame2_left: got %h expected 333333", f2l); end
    n_tests++;
    if (r2 !== 32'h0) begin n_fail++; $display("FAIL ur_frame2_right_zero: got %h expected 00000000", r2); end
    n_tests++;
    if ({ur127, cnt127} !== {1'b1, 16'd1}) begin
      n_fail++; $display("FAIL ur_flag_count: got flag=%b count=%h expected 1/0001", ur127, cnt127);
    end
    n_tests++;
    if (ready_mid !== 1'b0) begin n_fail++; $display("FAIL ur_resync_hold: sample_ready got %b expected 0", ready_mid); end
    n_tests++;
    if (f3 !== 24'h444444) begin n_fail++; $display("FAIL ur_frame3_slot0: got %h expected 444444", f3); end
    n_tests++;
    if (f3lr !== 1'b0) begin n_fail++; $display("FAIL ur_frame3_lr: got %b expected 0", f3lr); end
    n_tests++;
    if (underrun_count !== 16'd1) begin n_fail++; $display("FAIL ur_count_after_recover: got %h expected 0001", underrun_count); end
    enable = 0;
    @(negedge clk);
  endtask

  task automatic test_drop;
    logic [7:0] v;
    logic       d, l, lrs;
    int         c, c_first;
    q.push_back(24'hFFFFFF);
    mode_lj = 1; bclk_div = 1; mclk_div = 0; enable = 1;
    for (int k = 0; k < 6; k++) get_bit(d, l, c);
    repeat (2) @(negedge clk);
    n_tests++;
    if ({i2s_clock, i2s_data} !== 2'b11) begin
      n_fail++; $display("FAIL drop_pre: bclk,data got %b expected 11", {i2s_clock, i2s_data});
    end
    enable = 0;
    @(negedge clk);
    n_tests++;
    if ({i2s_mclock, i2s_clock, i2s_data, i2s_lr, sample_ready} !== 5'b0) begin
      n_fail++; $display("FAIL drop_outputs: got %b expected 00000",
                         {i2s_mclock, i2s_clock, i2s_data, i2s_lr, sample_ready});
    end
    n_tests++;
    if ({underrun, underrun_count} !== {1'b1, 16'd1}) begin
      n_fail++; $display("FAIL drop_persist: got flag=%b count=%h expected 1/0001", underrun, underrun_count);
    end
    q.push_back(24'hF0F0F0);
    enable = 1;
    lrs = 0; c_first = 0;
    for (int k = 0; k < 8; k++) begin
      get_bit(d, l, c);
      if (k == 0) c_first = c;
      v[7-k] = d; lrs = lrs | l;
    end
    n_tests++;
    if ({lrs, v} !== {1'b0, 8'hF0}) begin
      n_fail++; $display("FAIL drop_restart: got lr=%b bits=%h expected 0/f0", lrs, v);
    end
    n_tests++;
    if (c_first !== 5) begin n_fail++; $display("FAIL drop_first_fall: got %0d cycles expected 5", c_first); end
    enable = 0;
    @(negedge clk);
  endtask

  task automatic test_four;
    logic [63:0] dv, lv, ev;
    logic [15:0] val;
    logic        d, l;
    logic [15:0] cnt_resync;
    q4.push_back(16'h0001); q4.push_back(16'h0002); q4.push_back(16'h0003); q4.push_back(16'h0004);
    mode_lj_4 = 1; bclk_div_4 = 0; mclk_div_4 = 0; enable_4 = 1;
    for (int k = 0; k < 64; k++) begin
      get_bit4(d, l);
      dv[k] = d; lv[k] = l;
    end
    ev = '0;
    for (int s = 0; s < 4; s++) begin
      val = 16'(s + 1);
      for (int i = 0; i < 16; i++) ev[16*s + i] = val[15-i];
    end
    n_tests++;
    if (dv !== ev) begin n_fail++; $display("FAIL tdm4_data: got %h expected %h", dv, ev); end
    n_tests++;
    if (lv !== {32'hFFFF_FFFF, 32'h0}) begin
      n_fail++; $display("FAIL tdm4_lr: got %h expected ffffffff00000000", lv);
    end
    for (int k = 64; k < 128; k++) get_bit4(d, l);
    cnt_resync = underrun_count_4;
    n_tests++;
    if (cnt_resync !== 16'd4) begin n_fail++; $display("FAIL tdm4_resync_count: got %h expected 0004", cnt_resync); end
    @(negedge clk);
    underrun_clear_4 = 1;
    get_bit4(d, l);
    underrun_clear_4 = 0;
    n_tests++;
    if ({underrun_4, underrun_count_4} !== {1'b1, 16'd1}) begin
      n_fail++; $display("FAIL tdm4_clear_coincide: got flag=%b count=%h expected 1/0001",
                         underrun_4, underrun_count_4);
    end
    enable_4 = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lj();
    test_i2s();
    test_clocks();
    test_underrun();
    test_drop();
    test_four();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_engine.md
Name: i2s_tx_engine

Overview:
- Parametrised next-generation I2S/TDM transmit engine for the wishbone I2S slave.
- Generates MCLK and BCLK from the system clock and serialises samples from a valid/ready stream.
- Sample width, slot width and channel count are generic; I2S and left-justified modes are selectable.
- Adds underrun detection, a saturating underrun counter, and frame resynchronisation after underrun.

Parameters:
- SAMPLE_WIDTH, 24: audio bits per sample, sent MSB first.
- SLOT_WIDTH, 32: bit periods per channel slot; must be >= SAMPLE_WIDTH. The tail of each slot is zero padded.
- NUM_CHANNELS, 2: slots per frame; must be even and >= 2.
- DIV_WIDTH, 16: width of the clock divider inputs.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  engine run.
- mode_lj  in  1  0 = I2S (one-bit data delay), 1 = left-justified.
- bclk_div  in  DIV_WIDTH  BCLK half-period = bclk_div+1 clk cycles.
- mclk_div  in  DIV_WIDTH  MCLK half-period = mclk_div+1 clk cycles.
- sample_valid  in  1  upstream sample available.
- sample_ready  out  1  engine accepts sample this cycle.
- sample_data  in  SAMPLE_WIDTH  sample; samples arrive in slot order, channel 0 first.
- underrun_clear  in  1  clears underrun and underrun_count.
- underrun  out  1  sticky underrun flag.
- underrun_count  out  16  saturating count of underrun slots.
- i2s_mclock  out  1  master clock.
- i2s_clock  out  1  bit clock.
- i2s_data  out  1  serial data.
- i2s_lr  out  1  frame/channel select.

Behaviour:
- Reset: all outputs 0. Counters, holding register, shift register and config latches cleared.
- enable low: same idle state as reset, except underrun and underrun_count hold their values. Dropping enable mid-frame aborts immediately; no partial-frame completion.
- Config latch: mode_lj, bclk_div and mclk_div are latched in the cycle enable rises. Later changes are ignored until the next rising edge of enable.
- MCLK: free-running toggle every mclk_div+1 cycles while enabled.
- BCLK: starts low and toggles every bclk_div+1 cycles. bclk_div=0 gives clk/2.
- Frame position:
  - FRAME_BITS = NUM_CHANNELS*SLOT_WIDTH. Frame index fi advances once per BCLK falling edge and wraps FRAME_BITS-1 -> 0.
  - The first falling edge after enable is fi=0.
  - All outputs change only on the cycle of a BCLK falling edge.
- i2s_lr: 0 while fi < FRAME_BITS/2, else 1. It is identical in both modes.
- Data index:
  - LJ mode: di = fi.
  - I2S mode: di = fi-1 mod FRAME_BITS. The very first bit period after enable outputs 0.
- Data bit: shift-register MSB when (di mod SLOT_WIDTH) < SAMPLE_WIDTH, else 0.
- Holding register (1 entry): sample_ready = enable && !hold_valid. A transfer occurs when sample_valid && sample_ready.
- Slot load: on the falling edge where di mod SLOT_WIDTH == 0:
  - If hold_valid: shift <= hold and hold_valid is cleared. A same-cycle upstream transfer refills hold.
  - Else underrun: shift <= 0, underrun <= 1, underrun_count increments, saturating at 16'hFFFF.
- Resync: after an underrun the engine enters RESYNC.
  - Every remaining slot of the current frame outputs 0, and each counts as an underrun only if hold is empty at its load point.
  - In RESYNC, hold is not consumed until the load for slot 0 of the next frame, so channel 0 stays aligned.
- State machine:
  - IDLE -> RUN on enable.
  - RUN -> RESYNC on underrun.
  - RESYNC -> RUN at the next slot-0 load where hold_valid.
  - Any state -> IDLE on !enable or rst.
- underrun_clear: clears the flag and the count. If it coincides with a new underrun, the result is flag=1, count=1.

Decomposition:
- Package i2s_pkg:
  - FRAME_BITS and slot/data index width functions (clog2).
  - Mode encoding constants MODE_I2S=0, MODE_LJ=1.
  - State encodings IDLE, RUN, RESYNC.
- Sub-module i2s_clock_gen: two divider counters producing i2s_mclock, i2s_clock and a single-cycle bclk_fall strobe.
- The serialiser, holding register and underrun logic stay in i2s_tx_engine.

Test Plan:
- Defaults, LJ mode, bclk_div=1:
  - Feed 24'hABCDEF then 24'h123456.
  - Expect: LR=0 slot carries A,B,C,D,E,F MSB-first then 8 zeros; LR=1 slot carries 123456. Each bit lasts 4 clk.
- Same stimulus, I2S mode:
  - Expect the identical stream delayed one BCLK period.
  - The MSB of 0xABCDEF appears on the second falling edge after the LR 1->0 transition.
- bclk_div=0, mclk_div=3:
  - Expect BCLK period 2 clk and MCLK period 8 clk.
  - Change bclk_div mid-run -> no effect until enable is toggled.
- Underrun:
  - Supply only the left sample of frame 2.
  - Expect: right slot all zeros, underrun=1, count=1, nothing consumed in RESYNC.
  - The next supplied sample goes out in frame 3 slot 0 (LR=0).
- Drop enable mid-slot:
  - Expect all outputs 0 the next cycle and sample_ready=0. Counters persist.
  - Re-enable -> frame restarts at fi=0.
- NUM_CHANNELS=4, SAMPLE_WIDTH=16, SLOT_WIDTH=16:
  - Feed 16'h0001..16'h0004.
  - Expect LR low for slots 0-1 and high for slots 2-3, each slot 16 bits.
  - Also assert underrun_clear in the same cycle as a new underrun -> count=1.
